// File: rtl/dram_slv_pkg.sv
// Shared constants and types for the DRAM slave: bus widths, default depth,
// response-buffer depth and the response record that sits in the buffer.
package dram_slv_pkg;

  localparam int MEM_BUS_W      = 32;    // data bus width
  localparam int MEM_ADDR_BUS_W = 32;    // byte-address bus width
  localparam int MEM_WEM_W      = MEM_BUS_W / 8;
  localparam int DRAM_DEPTH     = 4096;  // words; power of two, >= 4
  localparam int RSP_BUF_DEPTH  = 2;     // queued read responses

  typedef logic [MEM_BUS_W-1:0]      mem_bus_t;
  typedef logic [MEM_ADDR_BUS_W-1:0] mem_addr_t;
  typedef logic [MEM_WEM_W-1:0]      mem_wem_t;

  // One read response as it travels through the buffer.
  typedef struct packed {
    mem_bus_t rdata;
    logic     error;
  } rsp_t;

endpackage

// File: rtl/dram_slv_if.sv
// Command/response bus between a master and the DRAM slave.
//
// Handshake: both channels are valid/ready. A beat transfers on a rising
// edge where valid and ready are both 1. Once valid is raised the sender
// holds it and its payload until the transfer; ready never depends
// combinationally on valid. Writes complete on command transfer and have
// no response; each read produces exactly one response, in order.
interface dram_slv_if;
  import dram_slv_pkg::*;

  mem_bus_t  slv_cmd_wdata;
  mem_addr_t slv_cmd_addr;
  logic      slv_cmd_we;
  mem_wem_t  slv_cmd_wem;
  logic      slv_cmd_valid;
  logic      slv_cmd_ready;
  mem_bus_t  slv_rsp_rdata;
  logic      slv_rsp_valid;
  logic      slv_rsp_ready;
  logic      slv_rsp_error;

  modport master (
    output slv_cmd_wdata, slv_cmd_addr, slv_cmd_we, slv_cmd_wem, slv_cmd_valid,
    input  slv_cmd_ready,
    input  slv_rsp_rdata, slv_rsp_valid, slv_rsp_error,
    output slv_rsp_ready
  );

  modport slave (
    input  slv_cmd_wdata, slv_cmd_addr, slv_cmd_we, slv_cmd_wem, slv_cmd_valid,
    output slv_cmd_ready,
    output slv_rsp_rdata, slv_rsp_valid, slv_rsp_error,
    input  slv_rsp_ready
  );

endinterface

// File: rtl/dram_sp.sv
// Single-port synchronous RAM with byte-masked write and a 1-cycle
// registered read. The read register only changes on a read access, so a
// later write never disturbs data already read out. Contents are not reset.
module dram_sp
  import dram_slv_pkg::*;
#(
  parameter int DEPTH = DRAM_DEPTH,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          en,
  input  logic          we,
  input  mem_wem_t      wem,
  input  logic [AW-1:0] addr,
  input  mem_bus_t      wdata,
  output mem_bus_t      rdata
);

  mem_bus_t mem [DEPTH];
  mem_bus_t rdata_q;

  // Port access: masked byte write, or registered read.
  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        for (int i = 0; i < MEM_WEM_W; i++) begin
          if (wem[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
        end
      end else begin
        rdata_q <= mem[addr];
      end
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/dram_slv.sv
// DRAM slave: decodes bus commands onto a dram_sp instance, tracks the one
// read that can be in flight inside the RAM, and queues read responses in a
// 2-entry buffer. Credit rule: a command is accepted only while queued
// responses plus in-flight reads is below the buffer depth, so every read
// always has a slot waiting for it.
module dram_slv
  import dram_slv_pkg::*;
#(
  parameter int DEPTH = DRAM_DEPTH
) (
  input  logic       clk,
  input  logic       rst_n,
  dram_slv_if.slave  slv,
  output logic       err_o,
  input  logic       err_clr_i
);

  localparam int AW = $clog2(DEPTH);

  // Command decode
  logic          cmd_ready;
  logic          accept;
  logic          oor;
  logic [AW-1:0] word_idx;
  logic          ram_en;
  mem_bus_t      ram_rdata;

  // Response path
  rsp_t       buf_q [RSP_BUF_DEPTH];
  rsp_t       buf_d [RSP_BUF_DEPTH];
  logic       wr_ptr_q, wr_ptr_d;
  logic       rd_ptr_q, rd_ptr_d;
  logic [1:0] count_q, count_d;
  logic       inflight_q, inflight_d;
  logic       inflight_err_q, inflight_err_d;
  logic       err_q, err_d;
  rsp_t       inflight_rsp;
  rsp_t       rsp_out;
  logic       rsp_valid;
  logic       pop;
  logic       pop_buf;
  logic       push;

  // Address decode, credit check and acceptance.
  always_comb begin
    oor       = |(slv.slv_cmd_addr >> (AW + 2));
    word_idx  = slv.slv_cmd_addr[AW+1:2];
    cmd_ready = ({1'b0, count_q} + {2'b00, inflight_q}) < 3'(RSP_BUF_DEPTH);
    accept    = slv.slv_cmd_valid & cmd_ready;
    ram_en    = accept & ~oor;
  end

  dram_sp #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk   (clk),
    .en    (ram_en),
    .we    (slv.slv_cmd_we),
    .wem   (slv.slv_cmd_wem),
    .addr  (word_idx),
    .wdata (slv.slv_cmd_wdata),
    .rdata (ram_rdata)
  );

  // Response selection: buffer head first, else the read leaving the RAM
  // this cycle (gives the one-cycle read latency), else zeros.
  always_comb begin
    inflight_rsp.error = inflight_err_q;
    inflight_rsp.rdata = inflight_err_q ? '0 : ram_rdata;
    rsp_valid          = (count_q != 2'd0) | inflight_q;
    if (count_q != 2'd0)  rsp_out = buf_q[rd_ptr_q];
    else if (inflight_q)  rsp_out = inflight_rsp;
    else                  rsp_out = '0;
    pop     = rsp_valid & slv.slv_rsp_ready;
    pop_buf = pop & (count_q != 2'd0);
    // The in-flight read is parked unless it is consumed straight away.
    push    = inflight_q & ~(pop & (count_q == 2'd0));
  end

  // Next-state for buffer, in-flight tracker and sticky error.
  always_comb begin
    buf_d          = buf_q;
    wr_ptr_d       = wr_ptr_q;
    rd_ptr_d       = rd_ptr_q;
    count_d        = count_q;
    inflight_d     = accept & ~slv.slv_cmd_we;
    inflight_err_d = accept & ~slv.slv_cmd_we & oor;
    if (push) begin
      buf_d[wr_ptr_q] = inflight_rsp;
      wr_ptr_d        = ~wr_ptr_q;
    end
    if (pop_buf) rd_ptr_d = ~rd_ptr_q;
    case ({push, pop_buf})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
    // A new error in the same cycle as a clear wins.
    err_d = (err_q & ~err_clr_i) | (accept & oor);
  end

  // State registers; reset drops all pending responses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < RSP_BUF_DEPTH; i++) buf_q[i] <= '0;
      wr_ptr_q       <= 1'b0;
      rd_ptr_q       <= 1'b0;
      count_q        <= 2'd0;
      inflight_q     <= 1'b0;
      inflight_err_q <= 1'b0;
      err_q          <= 1'b0;
    end else begin
      buf_q          <= buf_d;
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      count_q        <= count_d;
      inflight_q     <= inflight_d;
      inflight_err_q <= inflight_err_d;
      err_q          <= err_d;
    end
  end

  assign slv.slv_cmd_ready = cmd_ready;
  assign slv.slv_rsp_valid = rsp_valid;
  assign slv.slv_rsp_rdata = rsp_out.rdata;
  assign slv.slv_rsp_error = rsp_out.error;
  assign err_o             = err_q;

endmodule

// File: doc/dram_slv.md
DRAM_SLV -- requirements
Module: dram_slv

Interface
REQ-001 Parameter DEPTH, default 4096, number of 32-bit words; SHALL be a power of two, minimum 4.
REQ-002 clk  input  1  clock; all state SHALL update on the rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 slv_cmd_wdata  input  32  write data.
REQ-005 slv_cmd_addr  input  32  byte address, offset within this slave.
REQ-006 slv_cmd_we  input  1  1 = write, 0 = read.
REQ-007 slv_cmd_wem  input  4  write byte mask; bit i enables byte i (bits 8i+7:8i).
REQ-008 slv_cmd_valid  input  1  master command request.
REQ-009 slv_cmd_ready  output  1  slave can accept a command.
REQ-010 slv_rsp_rdata  output  32  read data.
REQ-011 slv_rsp_valid  output  1  response available.
REQ-012 slv_rsp_ready  input  1  master accepts response.
REQ-013 slv_rsp_error  output  1  response is an error; qualified by slv_rsp_valid.
REQ-014 err_o  output  1  sticky error flag.
REQ-015 err_clr_i  input  1  synchronous clear of err_o.

Function
REQ-016 A command SHALL be accepted in a cycle only when slv_cmd_valid and slv_cmd_ready are both 1.
REQ-017 An accepted write SHALL complete at acceptance and SHALL produce no response.
REQ-018 An accepted read SHALL produce exactly one response, in acceptance order.
REQ-019 A response SHALL be consumed in a cycle only when slv_rsp_valid and slv_rsp_ready are both 1.
REQ-020 The word index SHALL be addr[log2(DEPTH)+1:2]; addr[1:0] SHALL be ignored.
REQ-021 An address is out of range when any of addr[31:log2(DEPTH)+2] is nonzero.
REQ-022 An in-range write SHALL update only the bytes selected by wem; wem=0 SHALL leave memory unchanged.
REQ-023 An out-of-range write SHALL leave memory unchanged and SHALL set err_o.
REQ-024 An out-of-range read SHALL respond with rdata=0 and error=1, and SHALL set err_o.
REQ-025 An in-range read SHALL respond with error=0.
REQ-026 Read latency: with no responses queued, a read accepted at edge T SHALL drive slv_rsp_valid=1 in the cycle after edge T.
REQ-027 Responses SHALL be held in a 2-entry buffer.
REQ-028 slv_cmd_ready SHALL be 1 when queued responses plus in-flight reads is less than 2; otherwise it SHALL be 0. Writes use the same rule.
REQ-029 slv_cmd_ready SHALL NOT depend combinationally on slv_cmd_valid.
REQ-030 Back-to-back reads with slv_rsp_ready held at 1 SHALL sustain one read per cycle.
REQ-031 While slv_rsp_valid=1 and slv_rsp_ready=0, slv_rsp_rdata and slv_rsp_error SHALL remain stable.
REQ-032 A read accepted in the cycle after a write to the same word SHALL return the written data.
REQ-033 A write accepted while read responses are queued SHALL NOT alter those queued responses.
REQ-034 When err_clr_i and a new error occur in the same cycle, err_o SHALL be 1 afterwards (set wins).
REQ-035 slv_rsp_valid SHALL be 0 whenever the buffer is empty and no read is in flight.

Reset
REQ-036 On rst_n low, the following SHALL be forced, asynchronously and regardless of clk:
- slv_rsp_valid=0
- slv_rsp_rdata=0
- slv_rsp_error=0
- err_o=0
- buffer and in-flight state empty
- slv_cmd_ready=1 once rst_n is high
REQ-037 Reset mid-transaction SHALL discard all pending responses; memory contents SHALL NOT be reset.

Structure
REQ-038 Bus widths SHALL come from the shared defines.v (`MemBus, `MemAddrBus); DEPTH and the response-buffer depth SHALL be named constants there.
REQ-039 Storage SHALL be a sub-module dram_sp: single-port synchronous RAM, byte-masked write, 1-cycle read.
REQ-040 The response buffer and credit logic SHALL reside in dram_slv.

Verification
REQ-041 Write 0x12345678 at 0x10 with wem=4'hF, then read 0x10 -> response 0x12345678, error=0, one cycle after acceptance.
REQ-042 Write 0xAABBCCDD at 0x20 with wem=4'b0101 over existing 0x00000000, then read 0x20 -> 0x00BB00DD.
REQ-043 Issue 3 reads with slv_rsp_ready=0 ->
- 2 reads accepted, slv_cmd_ready=0
- after ready is raised: responses in order, third read accepted
- no response lost or duplicated
REQ-044 With DEPTH=4096:
- read 0x4000 -> rdata=0, error=1, err_o=1
- write 0x4000 -> no response, memory unchanged
- err_clr_i pulse -> err_o=0
REQ-045 Streaming 16 reads with slv_rsp_ready=1 -> 16 responses on 16 consecutive cycles.
REQ-046 Assert rst_n low with 2 responses queued -> slv_rsp_valid=0 immediately; after release, read of a previously written word returns the preserved data.
